// File: rtl/contador_monitor.sv
`default_nettype none
// ============================================================================
// Module      : contador_monitor
// Description : Locks onto a 4-bit bouncing up/down counter, tracks direction,
//               counts sweeps and flags any step that is not the expected +/-1.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_monitor #(
    parameter int SWEEP_W     = 8,
    parameter int ERR_W       = 4,
    parameter bit AUTO_RESYNC = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               valid,
    input  logic [3:0]         s_in,
    output logic               locked,
    output logic               dir,
    output logic               top_pulse,
    output logic               bottom_pulse,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               err,
    output logic [ERR_W-1:0]   err_count,
    output logic [3:0]         exp_s
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_UP    = 2'd1,
        ST_DOWN  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [SWEEP_W-1:0] c_SWEEP_MAX = '1;
    localparam logic [ERR_W-1:0]   c_ERR_MAX   = '1;

    state_t             r_state, w_state_nx;
    logic [3:0]         r_prev, w_prev_nx;
    logic               r_dir, w_dir_nx;
    logic               r_top, w_top_nx;
    logic               r_bot, w_bot_nx;
    logic [SWEEP_W-1:0] r_sweep, w_sweep_nx;
    logic               r_err, w_err_nx;
    logic [ERR_W-1:0]   r_err_cnt, w_err_cnt_nx;
    logic [3:0]         r_exp_s, w_exp_s_nx;
    logic [3:0]         w_expected;
    logic               w_match;

    // Only meaningful in UP/DOWN; the turn is taken before prev can wrap.
    assign w_expected = (r_state == ST_DOWN) ? (r_prev - 4'd1) : (r_prev + 4'd1);
    assign w_match    = (s_in == w_expected);

    always_comb begin
        w_state_nx   = r_state;
        w_prev_nx    = r_prev;
        w_dir_nx     = r_dir;
        w_top_nx     = 1'b0;
        w_bot_nx     = 1'b0;
        w_sweep_nx   = r_sweep;
        w_err_nx     = r_err;
        w_err_cnt_nx = r_err_cnt;
        w_exp_s_nx   = r_exp_s;
        if (clr) begin
            w_state_nx   = ST_SYNC;
            w_prev_nx    = 4'd0;
            w_dir_nx     = 1'b0;
            w_sweep_nx   = '0;
            w_err_nx     = 1'b0;
            w_err_cnt_nx = '0;
            w_exp_s_nx   = 4'd0;
        end else if (r_state == ST_ERROR) begin
            if (AUTO_RESYNC) begin
                w_state_nx = ST_SYNC;
            end
        end else if (valid) begin
            case (r_state)
                ST_SYNC: begin
                    if (s_in == 4'd0) begin
                        w_state_nx = ST_UP;
                        w_dir_nx   = 1'b0;
                        w_prev_nx  = s_in;
                    end else if (s_in == 4'd15) begin
                        w_state_nx = ST_DOWN;
                        w_dir_nx   = 1'b1;
                        w_prev_nx  = s_in;
                    end
                end
                default: begin
                    if (w_match) begin
                        w_prev_nx = s_in;
                        if (r_state == ST_UP && s_in == 4'd15) begin
                            w_state_nx = ST_DOWN;
                            w_dir_nx   = 1'b1;
                            w_top_nx   = 1'b1;
                        end else if (r_state == ST_DOWN && s_in == 4'd0) begin
                            w_state_nx = ST_UP;
                            w_dir_nx   = 1'b0;
                            w_bot_nx   = 1'b1;
                            if (r_sweep != c_SWEEP_MAX) begin
                                w_sweep_nx = r_sweep + 1'b1;
                            end
                        end
                    end else begin
                        // Mismatching sample is discarded; prev and dir hold.
                        w_state_nx = ST_ERROR;
                        w_err_nx   = 1'b1;
                        w_exp_s_nx = w_expected;
                        if (r_err_cnt != c_ERR_MAX) begin
                            w_err_cnt_nx = r_err_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_SYNC;
            r_prev    <= 4'd0;
            r_dir     <= 1'b0;
            r_top     <= 1'b0;
            r_bot     <= 1'b0;
            r_sweep   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_exp_s   <= 4'd0;
        end else begin
            r_state   <= w_state_nx;
            r_prev    <= w_prev_nx;
            r_dir     <= w_dir_nx;
            r_top     <= w_top_nx;
            r_bot     <= w_bot_nx;
            r_sweep   <= w_sweep_nx;
            r_err     <= w_err_nx;
            r_err_cnt <= w_err_cnt_nx;
            r_exp_s   <= w_exp_s_nx;
        end
    end

    assign locked       = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign dir          = r_dir;
    assign top_pulse    = r_top;
    assign bottom_pulse = r_bot;
    assign sweep_count  = r_sweep;
    assign err          = r_err;
    assign err_count    = r_err_cnt;
    assign exp_s        = r_exp_s;

endmodule
`default_nettype wire
